// File: rtl/riscv_pkg.sv
// riscv_pkg: register-file geometry and writeback request type shared by the
// writeback-side blocks.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: small synchronous FIFO with wrap-bit pointers; push and pop
// may happen in the same cycle.
module wb_result_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  r_wp, r_rp;
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (push && !full) r_wp <= r_wp + 1'b1;
      if (pop && !empty) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) r_mem[r_wp[AW-1:0]] <= din;
  assign empty = r_wp == r_rp;
  assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign head  = r_mem[r_rp[AW-1:0]];
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: sole driver of the register bank write port; merges pipeline
// writeback with buffered MDU results and tracks pending MDU destinations.
module wb_write_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN         = riscv_pkg::XLEN,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_wb_valid,
  input  logic [REG_ADDR_W-1:0] pipe_wb_rd,
  input  logic [XLEN-1:0]       pipe_wb_data,
  output logic                  pipe_hold,
  input  logic                  mdu_issue_valid,
  input  logic [REG_ADDR_W-1:0] mdu_issue_rd,
  input  logic                  mdu_res_valid,
  input  logic [REG_ADDR_W-1:0] mdu_res_rd,
  input  logic [XLEN-1:0]       mdu_res_data,
  output logic                  mdu_res_ready,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  hazard_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NUM_REGS-1:0]   busy_mask
);
  localparam int EW = REG_ADDR_W + XLEN;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic                  w_full, w_empty, w_push, w_pipe_win, w_fifo_win, w_starve_hit;
  logic [EW-1:0]         w_head;
  logic [REG_ADDR_W-1:0] w_head_rd, w_win_rd;
  logic [XLEN-1:0]       w_head_data, w_win_data;
  logic [NUM_REGS-1:0]   w_set, w_clr;
  logic                  r_we, r_hold;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [XLEN-1:0]       r_wdata;
  logic [NUM_REGS-1:0]   r_busy;
  logic [CW-1:0]         r_starve_cnt;

  wb_result_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_fifo_win),
    .din   ({mdu_res_rd, mdu_res_data}),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  // A registered hold hands the port to the FIFO regardless of the pipeline.
  always_comb begin
    mdu_res_ready = !w_full && !reset;
    w_push        = mdu_res_valid && mdu_res_ready;
    {w_head_rd, w_head_data} = w_head;
    w_pipe_win    = !r_hold && pipe_wb_valid;
    w_fifo_win    = !w_empty && (r_hold || !pipe_wb_valid);
    w_win_rd      = w_pipe_win ? pipe_wb_rd : w_fifo_win ? w_head_rd : '0;
    w_win_data    = w_pipe_win ? pipe_wb_data : w_fifo_win ? w_head_data : '0;
    w_starve_hit  = w_pipe_win && !w_empty && r_starve_cnt == CW'(STARVE_LIMIT - 1);
    w_set         = (mdu_issue_valid && mdu_issue_rd != '0) ? NUM_REGS'(1) << mdu_issue_rd : '0;
    w_clr         = (w_fifo_win && w_head_rd != '0) ? NUM_REGS'(1) << w_head_rd : '0;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_hold       <= 1'b0;
      r_busy       <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_we         <= |w_win_rd;
      r_waddr      <= w_win_rd;
      r_wdata      <= w_win_data;
      r_hold       <= w_starve_hit;
      r_busy       <= (r_busy & ~w_clr) | w_set;
      r_starve_cnt <= (w_pipe_win && !w_empty && !w_starve_hit) ? r_starve_cnt + 1'b1 : '0;
    end

  assign rf_we        = r_we;
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign pipe_hold    = r_hold;
  assign busy_mask    = r_busy;
  assign hazard_stall = id_valid && (r_busy[id_rs1] || r_busy[id_rs2] || r_busy[id_rd]);
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the write-port rules.
module tb_wb_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 0;
  logic        reset;
  logic        pipe_wb_valid, mdu_issue_valid, mdu_res_valid, id_valid;
  logic [4:0]  pipe_wb_rd, mdu_issue_rd, mdu_res_rd, id_rs1, id_rs2, id_rd;
  logic [31:0] pipe_wb_data, mdu_res_data;
  logic        pipe_hold, mdu_res_ready, hazard_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, busy_mask;

  logic [36:0] mq[$];
  logic [4:0]  infl[$];
  logic [31:0] mbusy;
  int          mcnt;
  logic        mhold, ewe;
  logic [4:0]  ewaddr;
  logic [31:0] ewdata;
  int          total = 0;
  int          bad = 0;

  wb_write_arbiter #(.XLEN(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_hold(pipe_hold),
    .mdu_issue_valid(mdu_issue_valid), .mdu_issue_rd(mdu_issue_rd),
    .mdu_res_valid(mdu_res_valid), .mdu_res_rd(mdu_res_rd), .mdu_res_data(mdu_res_data),
    .mdu_res_ready(mdu_res_ready),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .hazard_stall(hazard_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic idle();
    pipe_wb_valid = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
    mdu_issue_valid = 0; mdu_issue_rd = 0;
    mdu_res_valid = 0; mdu_res_rd = 0; mdu_res_data = 0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  task automatic model_reset();
    mq.delete(); infl.delete();
    mbusy = 0; mcnt = 0; mhold = 0; ewe = 0; ewaddr = 0; ewdata = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_update();
    logic pw, fw, push;
    logic [36:0] h;
    push = mdu_res_valid && mq.size() < DEPTH;
    fw   = mq.size() > 0 && (mhold || !pipe_wb_valid);
    pw   = !mhold && pipe_wb_valid;
    h    = fw ? mq[0] : '0;
    ewe    = pw ? pipe_wb_rd != 0 : fw ? h[36:32] != 0 : 1'b0;
    ewaddr = pw ? pipe_wb_rd : h[36:32];
    ewdata = pw ? pipe_wb_data : h[31:0];
    mcnt  = (pw && mq.size() > 0) ? mcnt + 1 : 0;
    mhold = mcnt == LIMIT;
    if (mhold) mcnt = 0;
    if (fw && h[36:32] != 0) mbusy[h[36:32]] = 1'b0;
    if (mdu_issue_valid && mdu_issue_rd != 0) mbusy[mdu_issue_rd] = 1'b1;
    if (fw) void'(mq.pop_front());
    if (push) begin
      mq.push_back({mdu_res_rd, mdu_res_data});
      if (infl.size() > 0) void'(infl.pop_front());
    end
    if (mdu_issue_valid) infl.push_back(mdu_issue_rd);
  endtask

  task automatic step();
    #1;
    chk("ready", 32'(mdu_res_ready), 32'(!reset && mq.size() < DEPTH));
    chk("hazard", 32'(hazard_stall),
        32'(id_valid && (mbusy[id_rs1] || mbusy[id_rs2] || mbusy[id_rd])));
    model_update();
    @(posedge clk);
    #1;
    chk("rf_we", 32'(rf_we), 32'(ewe));
    if (ewe) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(ewaddr));
      chk("rf_wdata", rf_wdata, ewdata);
    end
    chk("pipe_hold", 32'(pipe_hold), 32'(mhold));
    chk("busy_mask", busy_mask, mbusy);
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    id_valid = 1;
    #1;
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_waddr", 32'(rf_waddr), 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_hold", 32'(pipe_hold), 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_ready", 32'(mdu_res_ready), 0);
    chk("rst_hazard", 32'(hazard_stall), 0);
    model_reset();
    idle();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    int n;
    logic [4:0] r;
    reset = 0;
    idle();
    #2;
    do_reset();

    // basic pipeline write
    pipe_wb_valid = 1; pipe_wb_rd = 5; pipe_wb_data = 32'hDEADBEEF;
    step();
    chk("t1_we", 32'(rf_we), 1);
    chk("t1_waddr", 32'(rf_waddr), 5);
    chk("t1_wdata", rf_wdata, 32'hDEADBEEF);

    // pipe and MDU result collide; the pipe goes first
    idle(); mdu_issue_valid = 1; mdu_issue_rd = 7;
    step();
    chk("t2_busy7_set", 32'(busy_mask[7]), 1);
    idle(); pipe_wb_valid = 1; pipe_wb_rd = 1; pipe_wb_data = 32'h111;
    mdu_res_valid = 1; mdu_res_rd = 7; mdu_res_data = 32'h12;
    step();
    chk("t2_pipe_first", 32'(rf_waddr), 1);
    idle();
    step();
    chk("t2_mdu_we", 32'(rf_we), 1);
    chk("t2_mdu_waddr", 32'(rf_waddr), 7);
    chk("t2_mdu_wdata", rf_wdata, 32'h12);
    chk("t2_busy7_clr", 32'(busy_mask[7]), 0);

    // RAW and WAW stall on a pending MDU destination
    idle(); mdu_issue_valid = 1; mdu_issue_rd = 3;
    step();
    idle(); id_valid = 1; id_rs1 = 3;
    #1 chk("t3_raw", 32'(hazard_stall), 1);
    id_rs1 = 0; id_rd = 3;
    #1 chk("t3_waw", 32'(hazard_stall), 1);
    mdu_res_valid = 1; mdu_res_rd = 3; mdu_res_data = 32'h33;
    step();
    mdu_res_valid = 0;
    step();
    chk("t3_release", 32'(hazard_stall), 0);
    chk("t3_waddr", 32'(rf_waddr), 3);

    // starvation forces one FIFO slot after LIMIT pipe-won cycles
    idle(); mdu_issue_valid = 1; mdu_issue_rd = 9;
    step();
    idle(); pipe_wb_valid = 1; pipe_wb_rd = 10; pipe_wb_data = 32'hA0;
    mdu_res_valid = 1; mdu_res_rd = 9; mdu_res_data = 32'h99;
    step();
    mdu_res_valid = 0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      pipe_wb_rd = 5'(10 + i); pipe_wb_data = 32'hA0 + i;
      step();
      n++;
      if (pipe_hold) break;
    end
    chk("t4_starve_len", n, 4);
    pipe_wb_rd = 15; pipe_wb_data = 32'hAF;
    step();
    chk("t4_fifo_slot", 32'(rf_waddr), 9);
    chk("t4_hold_once", 32'(pipe_hold), 0);
    step();
    chk("t4_represent", 32'(rf_waddr), 15);
    chk("t4_represent_d", rf_wdata, 32'hAF);

    // results to x0 are consumed without a write
    idle(); mdu_issue_valid = 1; mdu_issue_rd = 0;
    step();
    step();
    idle(); pipe_wb_valid = 1; pipe_wb_rd = 16; mdu_res_valid = 1; mdu_res_data = 1;
    step();
    pipe_wb_rd = 17; mdu_res_data = 2;
    step();
    idle();
    #1 chk("t5_full", 32'(mdu_res_ready), 0);
    step();
    chk("t5_x0_we_a", 32'(rf_we), 0);
    step();
    chk("t5_x0_we_b", 32'(rf_we), 0);
    #1 chk("t5_drained", 32'(mdu_res_ready), 1);

    // fill with three results, then reset mid-fill
    for (int i = 20; i <= 22; i++) begin
      idle(); mdu_issue_valid = 1; mdu_issue_rd = 5'(i);
      step();
    end
    idle(); pipe_wb_valid = 1; pipe_wb_rd = 18; mdu_res_valid = 1; mdu_res_rd = 20;
    step();
    pipe_wb_rd = 19; mdu_res_rd = 21;
    step();
    pipe_wb_rd = 23; mdu_res_rd = 22;
    #1 chk("t6_full", 32'(mdu_res_ready), 0);
    chk("t6_busy", busy_mask, 32'h0070_0000);
    do_reset();
    #1 chk("t6_empty", 32'(mdu_res_ready), 1);
    step();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset();
      if (!(mhold && pipe_wb_valid)) begin
        pipe_wb_rd   = 5'($urandom_range(0, 31));
        pipe_wb_data = $urandom();
        pipe_wb_valid = ($urandom_range(0, 9) < 7) && !mbusy[pipe_wb_rd];
      end
      mdu_issue_valid = 0;
      r = 5'($urandom_range(0, 31));
      if (infl.size() < 3 && $urandom_range(0, 9) < 3 &&
          (r == 0 || (!mbusy[r] && !(pipe_wb_valid && pipe_wb_rd == r)))) begin
        mdu_issue_valid = 1;
        mdu_issue_rd = r;
      end
      mdu_res_valid = infl.size() > 0 && $urandom_range(0, 9) < 7;
      mdu_res_rd    = infl.size() > 0 ? infl[0] : 5'd0;
      mdu_res_data  = $urandom();
      id_valid = 1'($urandom_range(0, 1));
      id_rs1 = 5'($urandom_range(0, 31));
      id_rs2 = 5'($urandom_range(0, 31));
      id_rd  = 5'($urandom_range(0, 31));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
